// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control stage.
// The button debounce filter is enabled with the STOPWATCH_DEBOUNCE_EN macro.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    localparam int DEF_TICK_DIV        = 100000;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;

    // Raw button rise to state change, without debounce: two sync flops plus edge detect.
    localparam int EDGE_LATENCY = 3;

endpackage

// File: rtl/btn_conditioner.sv
// Button front end: 2-flop synchronizer, optional debounce (STOPWATCH_DEBOUNCE_EN),
// and a rising-edge detector producing a one-cycle event pulse.
module btn_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic ev
);

    logic [1:0] sync_q;
    logic       level;
    logic       level_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          accepted;

    // Accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            accepted <= 1'b0;
        end else if (sync_q[1] == accepted) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            accepted <= sync_q[1];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = accepted;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign ev = level & ~level_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause controller and tick prescaler feeding the stopwatch digit chain.
// Optional button debounce is selected with STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STOP_AT_FULL    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_start_stop,
    input  logic btn_reset,
    input  logic chain_at_max,
    output logic inc,
    output logic clear,
    output logic running,
    output logic done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic ss_ev;
    logic rst_ev;

    sw_state_e      state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           inc_q, inc_d;
    logic           clear_q, clear_d;
    logic           init_q;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_start_stop),
        .ev    (ss_ev)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_reset),
        .ev    (rst_ev)
    );

    // init_q forces one clear after reset: the digit counters have no reset of their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            inc_q   <= 1'b0;
            clear_q <= 1'b0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            inc_q   <= inc_d;
            clear_q <= clear_d;
            init_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        inc_d   = 1'b0;
        clear_d = init_q;

        case (state_q)
            IDLE: begin
                if (rst_ev) begin
                    clear_d = 1'b1;
                end else if (ss_ev) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (rst_ev) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                    presc_d = '0;
                end else if (ss_ev) begin
                    state_d = PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    // A tick with the chain already at all-9s saturates instead of wrapping.
                    if ((STOP_AT_FULL != 0) && chain_at_max) begin
                        state_d = DONE;
                    end else begin
                        inc_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            PAUSE: begin
                if (rst_ev) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                    presc_d = '0;
                end else if (ss_ev) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (rst_ev) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                    presc_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase

        if (clear_d) begin
            inc_d = 1'b0;
        end
    end

    assign inc     = inc_q;
    assign clear   = clear_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scenario bench for stopwatch_ctrl (TICK_DIV=4, DEBOUNCE_CYCLES=3, STOP_AT_FULL=1).
// Each entry: inputs driven for one cycle, expected {inc,clear,running,done} queued, then checked.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int TD = 4;
    localparam int DC = 3;
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int D = 2 + DC;
`else
    localparam int D = EDGE_LATENCY - 1;
`endif
    localparam int RUN_LEN = D + 14;

    logic clk;
    logic rst_n;
    logic btn_start_stop;
    logic btn_reset;
    logic chain_at_max;
    logic inc;
    logic clear;
    logic running;
    logic done;

    int checks;
    int errors;
    logic [3:0] exp_q[$];

    stopwatch_ctrl #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DC),
        .STOP_AT_FULL    (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (btn_start_stop),
        .btn_reset      (btn_reset),
        .chain_at_max   (chain_at_max),
        .inc            (inc),
        .clear          (clear),
        .running        (running),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [3:0] e, obs;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(4'b0000);
        obs = {inc, clear, running, done};
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_hold inc/clear/running/done got %b expected %b", obs, e);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k == 0) ? 4'b0100 : 4'b0000);
            @(posedge clk); #1;
            obs = {inc, clear, running, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_release[%0d] got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_run();
        logic [3:0] e, obs;
        int j;
        for (int k = 0; k < RUN_LEN; k++) begin
            j = k - D;
            btn_start_stop = (k < 10);
            btn_reset      = 1'b0;
            chain_at_max   = 1'b0;
            exp_q.push_back({(j > 0 && j % TD == 0), 1'b0, (j >= 0), 1'b0});
            @(posedge clk); #1;
            obs = {inc, clear, running, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL run[%0d] got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] e, obs;
        int j0;
        j0 = RUN_LEN - D;
        for (int k = 0; k < 12; k++) begin
            btn_start_stop = (k < 6);
            btn_reset      = (k < 6);
            if (k < D)       e = {((j0 + k) % TD == 0), 1'b0, 1'b1, 1'b0};
            else if (k == D) e = 4'b0100;
            else             e = 4'b0000;
            exp_q.push_back(e);
            @(posedge clk); #1;
            obs = {inc, clear, running, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL simultaneous[%0d] got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_pause_resume();
        logic [3:0] e, obs;
        logic run1, run2;
        int j, m;
        for (int k = 0; k < 52; k++) begin
            btn_start_stop = (k < 6) || (k >= 11 && k < 17) || (k >= 31 && k < 37);
            btn_reset      = (k >= 40 && k < 46);
            run1 = (k >= D) && (k < 11 + D);
            run2 = (k >= 31 + D) && (k < 40 + D);
            j = k - D;
            m = k - 31 - D;
            e = {(run1 && j > 0 && j % TD == 0) || (run2 && m > 0 && (2 + m) % TD == 0),
                 (k == 40 + D), run1 || run2, 1'b0};
            exp_q.push_back(e);
            @(posedge clk); #1;
            obs = {inc, clear, running, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL pause_resume[%0d] got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] e, obs;
        for (int k = 0; k < 44; k++) begin
            btn_start_stop = (k < 6) || (k >= 20 && k < 26);
            btn_reset      = (k >= 32 && k < 38);
            chain_at_max   = (k >= D + 2);
            if (k < D)                e = 4'b0000;
            else if (k < D + 4)       e = 4'b0010;
            else if (k < 32 + D)      e = 4'b0001;
            else if (k == 32 + D)     e = 4'b0100;
            else                      e = 4'b0000;
            exp_q.push_back(e);
            @(posedge clk); #1;
            obs = {inc, clear, running, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL saturation[%0d] got %b expected %b", k, obs, e);
            end
        end
        chain_at_max = 1'b0;
    endtask

    task automatic test_idle_reset();
        logic [3:0] e, obs;
        for (int k = 0; k < 12; k++) begin
            btn_start_stop = 1'b0;
            btn_reset      = (k < 6);
            exp_q.push_back((k == D) ? 4'b0100 : 4'b0000);
            @(posedge clk); #1;
            obs = {inc, clear, running, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL idle_reset[%0d] got %b expected %b", k, obs, e);
            end
        end
    endtask

`ifdef STOPWATCH_DEBOUNCE_EN
    task automatic test_glitch();
        logic [3:0] e, obs;
        logic run;
        int j;
        for (int k = 0; k < 34; k++) begin
            btn_start_stop = (k < 2) || (k >= 12 && k < 16);
            btn_reset      = (k >= 22 && k < 28);
            run = (k >= 12 + D) && (k < 22 + D);
            j = k - 12 - D;
            e = {(run && j > 0 && j % TD == 0), (k == 22 + D), run, 1'b0};
            exp_q.push_back(e);
            @(posedge clk); #1;
            obs = {inc, clear, running, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL glitch[%0d] got %b expected %b", k, obs, e);
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        logic [3:0] e, obs;
        for (int k = 0; k < D + 6; k++) begin
            btn_start_stop = (k < 6);
            btn_reset      = 1'b0;
            exp_q.push_back({(k == D + 4), 1'b0, (k >= D), 1'b0});
            @(posedge clk); #1;
            obs = {inc, clear, running, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL async_run[%0d] got %b expected %b", k, obs, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(4'b0000);
        obs = {inc, clear, running, done};
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_assert got %b expected %b", obs, e);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back((k == 0) ? 4'b0100 : 4'b0000);
            @(posedge clk); #1;
            obs = {inc, clear, running, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL async_release[%0d] got %b expected %b", k, obs, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        btn_start_stop = 1'b0;
        btn_reset      = 1'b0;
        chain_at_max   = 1'b0;
        test_reset();
        test_run();
        test_simultaneous();
        test_pause_resume();
        test_saturation();
        test_idle_reset();
`ifdef STOPWATCH_DEBOUNCE_EN
        test_glitch();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Upstream control stage for the cascaded mod-10 digit counters of the stopwatch datapath.
- Conditions the start/stop and reset buttons, runs a run/pause state machine, and divides the system clock into one-cycle `inc` pulses for the least-significant digit.
- Issues the one-cycle `clear` pulses for the whole digit chain.
- Accepts a chain-at-maximum indication from downstream so the display saturates instead of wrapping.

Parameters:
- TICK_DIV, 100000: clk cycles per `inc` pulse; must be at least 2; prescaler width is $clog2(TICK_DIV).
- DEBOUNCE_CYCLES, 1000: consecutive stable synchronized samples needed before a button level is accepted; used only with STOPWATCH_DEBOUNCE_EN.
- STOP_AT_FULL, 1: 1 means saturate in DONE when the chain is at maximum; 0 means free-run and let the chain wrap.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- btn_start_stop  in  1  raw asynchronous button, active-high
- btn_reset  in  1  raw asynchronous button, active-high
- chain_at_max  in  1  all digits at 9, combinational from downstream
- inc  out  1  one-cycle count pulse to the LSD counter
- clear  out  1  one-cycle synchronous clear to all digit counters
- running  out  1  high while in RUN
- done  out  1  high while in DONE

Behaviour:
- Reset values while rst_n is low: state = IDLE, prescaler = 0, inc = 0, running = 0, done = 0, clear = 0, init flag = 1.
- Post-reset clear: on the first clk edge after rst_n deasserts, clear = 1 for exactly one cycle. The digit counters have no reset of their own, so this pulse is mandatory.
- Button conditioning: 2-flop synchronizer, then an optional debounce filter, then a rising-edge detector.
  - Event pulses are ss_ev and rst_ev.
  - Without debounce, state reacts 3 cycles after the raw input rises.
- FSM states: IDLE, RUN, PAUSE, DONE. rst_ev has priority over ss_ev in every state.
- IDLE:
  - ss_ev: go to RUN, prescaler = 0.
  - rst_ev: clear = 1 for one cycle, stay in IDLE.
- RUN:
  - Prescaler counts 0 .. TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and inc = 1 for that one cycle (registered output).
  - ss_ev: go to PAUSE. The prescaler value is held and no inc is issued.
  - rst_ev: go to IDLE, clear = 1, prescaler = 0, and any inc due that cycle is suppressed.
- PAUSE:
  - ss_ev: go back to RUN and resume from the held prescaler value, so no partial tick is lost.
  - rst_ev: go to IDLE with clear.
- DONE (STOP_AT_FULL = 1 only):
  - Entry condition: in RUN, the prescaler would fire an inc while chain_at_max = 1. The inc is suppressed, done = 1, and the display stays at all-9s.
  - ss_ev is ignored.
  - rst_ev: go to IDLE with clear.
- STOP_AT_FULL = 0: chain_at_max is ignored, inc fires normally and the chain wraps.
- inc and clear are never high in the same cycle; clear wins.
- running = 1 exactly when state == RUN; done = 1 exactly when state == DONE.
- Asynchronous reset mid-operation returns to the reset values immediately, then the post-reset clear is issued.

Optional Feature:
- STOPWATCH_DEBOUNCE_EN defined:
  - Each synchronized button passes through a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it.
  - Any sample equal to the accepted level resets the counter.
  - The accepted level resets to 0.
- Not defined:
  - The accepted level equals the synchronizer output.
  - DEBOUNCE_CYCLES is unused.
  - No counter logic is generated.

Decomposition:
- Package stopwatch_pkg:
  - state enum sw_state_e {IDLE, RUN, PAUSE, DONE}, 2 bits;
  - default TICK_DIV and DEBOUNCE_CYCLES constants;
  - the edge-detect latency constant (3).
- Sub-module btn_conditioner: synchronizer, optional debounce and rising-edge pulse. Instantiated twice, once per button.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3, STOP_AT_FULL=1):
- Reset release: drive rst_n low, then release it -> clear = 1 on the first post-release cycle only; inc = 0, running = 0.
- Run timing: press start, hold 10 cycles -> running = 1 three cycles after the press; inc pulses are one cycle wide, exactly 4 cycles apart, starting 4 cycles after RUN entry.
- Pause/resume: pause at prescaler = 2, wait 20 cycles, resume -> no inc while paused; first inc 2 cycles after RUN re-entry.
- Simultaneous buttons: both buttons rise in the same cycle during RUN -> IDLE with one clear pulse, no inc, running = 0.
- Saturation: chain_at_max = 1 in RUN at a tick -> inc suppressed, done = 1; start press ignored; reset press -> IDLE, clear pulse, done = 0.
- Debounce (macro defined): 2-cycle glitch on btn_start_stop -> no state change; a 4-cycle stable press -> RUN after sync plus 3 stable cycles plus edge detect.
